// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply/divide sequencer for the execute stage.
// Shift-add multiply or restoring divide on magnitudes, sign fixup, one-cycle result pulse.
module multdiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic             flush,
   input  logic [WIDTH-1:0] operand_A,
   input  logic [WIDTH-1:0] operand_B,
   input  logic [4:0]       dest_reg_in,
   output logic             stall,
   output logic             busy,
   output logic             result_valid,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       result_reg,
   output logic             exception,
   output logic             status_wren
);

   typedef enum logic [2:0] {IDLE, MULT, DIV, FIXUP, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t             state, next_state;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   addend;
   logic               sign_neg;
   logic               is_div;
   logic [4:0]         dest_q;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic               accept;
   logic [WIDTH:0]     mult_sum;
   logic [WIDTH:0]     div_shifted, div_diff;
   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH-1:0]   quot_signed;
   logic               mult_ovf, div_ovf;
   logic [WIDTH-1:0]   fix_result;
   logic               fix_exc;

   // acc holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV.
   always_comb begin
      mag_a       = operand_A[WIDTH-1] ? -operand_A : operand_A;
      mag_b       = operand_B[WIDTH-1] ? -operand_B : operand_B;
      accept      = (state == IDLE) && ((next_state == MULT) || (next_state == DIV));
      mult_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, addend} : '0);
      div_shifted = acc[2*WIDTH-1:WIDTH-1];
      div_diff    = div_shifted - {1'b0, addend};
      prod_signed = sign_neg ? -acc : acc;
      quot_signed = sign_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      mult_ovf    = ~((&prod_signed[2*WIDTH-1:WIDTH-1]) | ~(|prod_signed[2*WIDTH-1:WIDTH-1]));
      div_ovf     = ~sign_neg & acc[WIDTH-1];
      fix_result  = is_div ? quot_signed : prod_signed[WIDTH-1:0];
      fix_exc     = is_div ? div_ovf : mult_ovf;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (flush) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start_mult) begin
                  next_state = MULT;
               end else if (start_div) begin
                  next_state = (operand_B == '0) ? DONE : DIV;
               end
            end
            MULT, DIV: begin
               if (count == '0) begin
                  next_state = FIXUP;
               end
            end
            FIXUP:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      stall       = ((state == IDLE) && (start_mult || start_div)) ||
                    (state == MULT) || (state == DIV) || (state == FIXUP);
      status_wren = result_valid & exception;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         acc      <= '0;
         addend   <= '0;
         sign_neg <= 1'b0;
         is_div   <= 1'b0;
         dest_q   <= '0;
      end else if (accept) begin
         count    <= CNT_LAST;
         acc      <= {{WIDTH{1'b0}}, (next_state == DIV) ? mag_a : mag_b};
         addend   <= (next_state == DIV) ? mag_b : mag_a;
         sign_neg <= operand_A[WIDTH-1] ^ operand_B[WIDTH-1];
         is_div   <= (next_state == DIV);
         dest_q   <= dest_reg_in;
      end else if (state == MULT) begin
         count <= count - CNT_ONE;
         acc   <= {mult_sum, acc[WIDTH-1:1]};
      end else if (state == DIV) begin
         count <= count - CNT_ONE;
         acc   <= div_diff[WIDTH] ? {div_shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
   end

   // Result fields only change on entry to DONE, so a flushed FIXUP leaves them untouched.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
         result_reg   <= '0;
         exception    <= 1'b0;
      end else begin
         busy         <= (next_state != IDLE);
         result_valid <= (next_state == DONE);
         if ((state == FIXUP) && (next_state == DONE)) begin
            result     <= fix_result;
            exception  <= fix_exc;
            result_reg <= dest_q;
         end else if ((state == IDLE) && (next_state == DONE)) begin
            result     <= '0;
            exception  <= 1'b1;
            result_reg <= dest_reg_in;
         end
      end
   end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: cycle-age model with plain signed arithmetic, checked every cycle,
// plus directed operations with hand-computed literal results.
module tb_multdiv_sequencer;

   localparam int WIDTH    = 32;
   localparam int DONE_AGE = WIDTH + 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start_mult = 1'b0;
   logic        start_div = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] operand_A = '0;
   logic [31:0] operand_B = '0;
   logic [4:0]  dest_reg_in = '0;
   logic        stall, busy, result_valid, exception, status_wren;
   logic [31:0] result;
   logic [4:0]  result_reg;

   int tests = 0;
   int failures = 0;
   bit check_en = 1'b0;

   multdiv_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .clock        (clock),
      .reset        (reset),
      .start_mult   (start_mult),
      .start_div    (start_div),
      .flush        (flush),
      .operand_A    (operand_A),
      .operand_B    (operand_B),
      .dest_reg_in  (dest_reg_in),
      .stall        (stall),
      .busy         (busy),
      .result_valid (result_valid),
      .result       (result),
      .result_reg   (result_reg),
      .exception    (exception),
      .status_wren  (status_wren)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Returns {exception, result} from signed arithmetic on the operands.
   function automatic logic [32:0] expectOp(input logic is_div, input logic [31:0] a, input logic [31:0] b);
      longint      p;
      logic [31:0] q;
      if (!is_div) begin
         p = longint'($signed(a)) * longint'($signed(b));
         return {(p > longint'(2147483647)) || (p < -longint'(2147483647) - 1), p[31:0]};
      end
      if (b == 32'h0) return {1'b1, 32'h0};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      return {1'b0, q};
   endfunction

   // m_age: 0 idle, 1..DONE_AGE-1 working, DONE_AGE result cycle.
   int          m_age = 0;
   logic [31:0] m_pend_res = '0;
   logic        m_pend_exc = 1'b0;
   logic [4:0]  m_pend_rd = '0;
   logic [31:0] m_out_res = '0;
   logic        m_out_exc = 1'b0;
   logic [4:0]  m_out_rd = '0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_age     <= 0;
         m_out_res <= '0;
         m_out_exc <= 1'b0;
         m_out_rd  <= '0;
      end else if (flush) begin
         m_age <= 0;
      end else if (m_age == 0) begin
         if (start_mult || (start_div && operand_B != 32'h0)) begin
            m_age                    <= 1;
            {m_pend_exc, m_pend_res} <= expectOp(!start_mult, operand_A, operand_B);
            m_pend_rd                <= dest_reg_in;
         end else if (start_div) begin
            m_age     <= DONE_AGE;
            m_out_res <= '0;
            m_out_exc <= 1'b1;
            m_out_rd  <= dest_reg_in;
         end
      end else if (m_age == DONE_AGE) begin
         m_age <= 0;
      end else begin
         m_age <= m_age + 1;
         if (m_age == DONE_AGE - 1) begin
            m_out_res <= m_pend_res;
            m_out_exc <= m_pend_exc;
            m_out_rd  <= m_pend_rd;
         end
      end
   end

   always @(negedge clock) begin
      if (check_en) begin
         checkOutput("busy", 32'(busy), 32'(m_age != 0));
         checkOutput("stall", 32'(stall),
                     32'(((m_age == 0) && (start_mult || start_div)) || ((m_age >= 1) && (m_age < DONE_AGE))));
         checkOutput("result_valid", 32'(result_valid), 32'(m_age == DONE_AGE));
         checkOutput("status_wren", 32'(status_wren), 32'((m_age == DONE_AGE) && m_out_exc));
         checkOutput("result", result, m_out_res);
         checkOutput("result_reg", 32'(result_reg), 32'(m_out_rd));
         checkOutput("exception", 32'(exception), 32'(m_out_exc));
      end
   end

   task automatic applyStimulus(input logic m, input logic d, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd);
      @(posedge clock);
      #1;
      start_mult  = m;
      start_div   = d;
      operand_A   = a;
      operand_B   = b;
      dest_reg_in = rd;
      @(posedge clock);
      #1;
      start_mult  = 1'b0;
      start_div   = 1'b0;
      operand_A   = 32'hDEAD_BEEF;
      operand_B   = 32'h0BAD_F00D;
      dest_reg_in = 5'd0;
   endtask

   // Returns the cycle (start cycle = 0) in which result_valid was seen, or 0 on timeout.
   task automatic runOperation(input logic m, input logic d, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd, output int lat);
      int cyc;
      applyStimulus(m, d, a, b, rd);
      lat = 0;
      cyc = 1;
      while (cyc <= 40) begin
         @(negedge clock);
         if (result_valid) begin
            lat = cyc;
            break;
         end
         cyc++;
      end
   endtask

   task automatic checkResult(input string name, input int lat, input int exp_lat, input logic [31:0] exp_res,
                              input logic exp_exc, input logic [4:0] exp_rd);
      checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({name, "_result"}, result, exp_res);
      checkOutput({name, "_exception"}, 32'(exception), 32'(exp_exc));
      checkOutput({name, "_status_wren"}, 32'(status_wren), 32'(exp_exc));
      checkOutput({name, "_result_reg"}, 32'(result_reg), 32'(exp_rd));
      checkOutput({name, "_model_result"}, m_out_res, exp_res);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat;
      int rv_count;
      logic m, d;
      logic [31:0] a, b;

      #2 reset = 1'b0;
      check_en = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_result_valid", 32'(result_valid), 32'd0);
      checkOutput("reset_result", result, 32'd0);
      checkOutput("reset_result_reg", 32'(result_reg), 32'd0);
      checkOutput("reset_exception", 32'(exception), 32'd0);
      #1 reset = 1'b1;

      // Asynchronous reset in the middle of a multiply.
      applyStimulus(1'b1, 1'b0, 32'd7, 32'd5, 5'd3);
      repeat (9) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      checkOutput("midreset_stall", 32'(stall), 32'd0);
      checkOutput("midreset_result_valid", 32'(result_valid), 32'd0);
      @(negedge clock);
      #1 reset = 1'b1;

      runOperation(1'b1, 1'b0, 32'd7, -32'sd3, 5'd9, lat);
      checkResult("mul_7x-3", lat, 34, 32'hFFFF_FFEB, 1'b0, 5'd9);

      runOperation(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd17, lat);
      checkResult("mul_ovf", lat, 34, 32'h0000_0000, 1'b1, 5'd17);

      runOperation(1'b1, 1'b0, 32'h8000_0000, 32'd1, 5'd1, lat);
      checkResult("mul_min_x1", lat, 34, 32'h8000_0000, 1'b0, 5'd1);

      runOperation(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, lat);
      checkResult("mul_min_x-1", lat, 34, 32'h8000_0000, 1'b1, 5'd2);

      runOperation(1'b0, 1'b1, -32'sd7, 32'd2, 5'd12, lat);
      checkResult("div_-7/2", lat, 34, 32'hFFFF_FFFD, 1'b0, 5'd12);

      runOperation(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, lat);
      checkResult("div_min/-1", lat, 34, 32'h8000_0000, 1'b1, 5'd13);

      runOperation(1'b0, 1'b1, 32'd100, -32'sd7, 5'd14, lat);
      checkResult("div_100/-7", lat, 34, 32'hFFFF_FFF2, 1'b0, 5'd14);

      runOperation(1'b0, 1'b1, 32'd5, 32'd0, 5'd4, lat);
      checkResult("div_by_zero", lat, 1, 32'h0000_0000, 1'b1, 5'd4);

      runOperation(1'b1, 1'b1, 32'd6, 32'd0, 5'd21, lat);
      checkResult("both_starts", lat, 34, 32'h0000_0000, 1'b0, 5'd21);

      // Ignored start while busy, then flush.
      applyStimulus(1'b1, 1'b0, 32'd9, 32'd9, 5'd6);
      repeat (4) @(posedge clock);
      #1;
      start_div   = 1'b1;
      operand_A   = 32'd3;
      operand_B   = 32'd0;
      dest_reg_in = 5'd30;
      @(posedge clock);
      #1;
      start_div   = 1'b0;
      dest_reg_in = 5'd0;
      repeat (6) @(posedge clock);
      #1 flush = 1'b1;
      @(posedge clock);
      #1 flush = 1'b0;
      @(negedge clock);
      checkOutput("flush_busy", 32'(busy), 32'd0);
      checkOutput("flush_stall", 32'(stall), 32'd0);
      rv_count = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (result_valid) rv_count++;
      end
      checkOutput("flush_no_result_valid", 32'(rv_count), 32'd0);

      // A few pseudo-random operations checked by the model alone.
      for (int i = 0; i < 6; i++) begin
         m = 1'($urandom_range(0, 1));
         d = ~m;
         a = $urandom;
         b = (i == 3) ? 32'h0 : ((i % 2 == 0) ? 32'($urandom_range(1, 5000)) : $urandom);
         runOperation(m, d, a, b, 5'(i + 7), lat);
         checkOutput("random_latency", 32'(lat), (d && b == 32'h0) ? 32'd1 : 32'd34);
      end

      repeat (3) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
